// File: rtl/wb_sequencer.sv
// Multicycle write-back sequencer: finishes one retiring instruction by waiting on memory
// for loads, driving the write-back mux and register-file write port, and signalling completion.
module wb_sequencer #(
    parameter int TIMEOUT    = 16,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  START,
    input  logic [2:0]            WB_CLASS,
    input  logic [REG_ADDR_W-1:0] RD,
    input  logic                  LT_FLAG,
    input  logic                  MEM_READY,
    output logic                  MEM_READ,
    output logic                  MEM_DATA_LOAD,
    output logic [2:0]            SELECT,
    output logic                  REG_WRITE,
    output logic [REG_ADDR_W-1:0] WR_ADDR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_LOAD = 3'b001;
    localparam logic [2:0] CLS_SLT  = 3'b010;
    localparam logic [2:0] CLS_LINK = 3'b011;
    localparam logic [2:0] CLS_NONE = 3'b100;

    localparam logic [2:0] SEL_ALU  = 3'b000;
    localparam logic [2:0] SEL_MEM  = 3'b001;
    localparam logic [2:0] SEL_ONE  = 3'b010;
    localparam logic [2:0] SEL_ZERO = 3'b011;
    localparam logic [2:0] SEL_PC   = 3'b100;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MEM_WAIT = 3'd1,
        WB       = 3'd2,
        FIN      = 3'd3,
        ABORT    = 3'd4
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [2:0]              class_r;
    logic [REG_ADDR_W-1:0]   rd_r;
    logic                    lt_r;
    logic                    mem_read_r;
    logic [2:0]              select_r;
    logic                    reg_write_r;
    logic [REG_ADDR_W-1:0]   wr_addr_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;

    function automatic logic [2:0] wb_select(input logic [2:0] cls, input logic lt);
        logic [2:0] sel;
        case (cls)
            CLS_ALU:  sel = SEL_ALU;
            CLS_LOAD: sel = SEL_MEM;
            CLS_SLT:  sel = lt ? SEL_ONE : SEL_ZERO;
            CLS_LINK: sel = SEL_PC;
            default:  sel = SEL_ALU;
        endcase
        return sel;
    endfunction

    // Sequencer FSM; outputs are loaded alongside the state they belong to, so they
    // are valid for exactly the cycles that state is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            class_r     <= 3'b000;
            rd_r        <= {REG_ADDR_W{1'b0}};
            lt_r        <= 1'b0;
            mem_read_r  <= 1'b0;
            select_r    <= 3'b000;
            reg_write_r <= 1'b0;
            wr_addr_r   <= {REG_ADDR_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            mem_read_r  <= 1'b0;
            select_r    <= 3'b000;
            reg_write_r <= 1'b0;
            wr_addr_r   <= {REG_ADDR_W{1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (START) begin
                        class_r <= WB_CLASS;
                        rd_r    <= RD;
                        lt_r    <= LT_FLAG;
                        busy_r  <= 1'b1;
                        case (WB_CLASS)
                            CLS_ALU, CLS_SLT, CLS_LINK: begin
                                state_r     <= WB;
                                select_r    <= wb_select(WB_CLASS, LT_FLAG);
                                reg_write_r <= (RD != {REG_ADDR_W{1'b0}});
                                wr_addr_r   <= RD;
                            end
                            CLS_LOAD: begin
                                state_r    <= MEM_WAIT;
                                cnt_r      <= {CNT_W{1'b0}};
                                mem_read_r <= 1'b1;
                            end
                            CLS_NONE: begin
                                state_r <= FIN;
                                done_r  <= 1'b1;
                            end
                            default: begin
                                state_r <= ABORT;
                                done_r  <= 1'b1;
                                err_r   <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    busy_r <= 1'b1;
                    // Ready wins over the timeout on the last allowed wait cycle.
                    if (MEM_READY) begin
                        state_r     <= WB;
                        select_r    <= wb_select(class_r, lt_r);
                        reg_write_r <= (rd_r != {REG_ADDR_W{1'b0}});
                        wr_addr_r   <= rd_r;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        state_r <= ABORT;
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                    end else begin
                        state_r    <= MEM_WAIT;
                        cnt_r      <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        mem_read_r <= 1'b1;
                    end
                end
                WB: begin
                    state_r <= FIN;
                    busy_r  <= 1'b1;
                    done_r  <= 1'b1;
                end
                FIN: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                ABORT: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // The data-register strobe must land in the very cycle memory reports valid data.
    assign MEM_DATA_LOAD = mem_read_r & MEM_READY;

    assign MEM_READ  = mem_read_r;
    assign SELECT    = select_r;
    assign REG_WRITE = reg_write_r;
    assign WR_ADDR   = wr_addr_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign ERR       = err_r;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed scenarios plus random transactions, each checked cycle by
// cycle against an expected-output trace derived from the class/latency rules.
module tb_wb_sequencer;

    localparam int T = 4;

    logic       clk;
    logic       reset_n;
    logic       START;
    logic [2:0] WB_CLASS;
    logic [4:0] RD;
    logic       LT_FLAG;
    logic       MEM_READY;
    logic       MEM_READ;
    logic       MEM_DATA_LOAD;
    logic [2:0] SELECT;
    logic       REG_WRITE;
    logic [4:0] WR_ADDR;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    int checks = 0;
    int errors = 0;

    wb_sequencer #(.TIMEOUT(T), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .START(START), .WB_CLASS(WB_CLASS), .RD(RD),
        .LT_FLAG(LT_FLAG), .MEM_READY(MEM_READY), .MEM_READ(MEM_READ),
        .MEM_DATA_LOAD(MEM_DATA_LOAD), .SELECT(SELECT), .REG_WRITE(REG_WRITE),
        .WR_ADDR(WR_ADDR), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {MEM_READ, MEM_DATA_LOAD, SELECT, REG_WRITE, WR_ADDR, BUSY, DONE, ERR}
    function automatic logic [13:0] vec(input logic mr, input logic mdl, input logic [2:0] sel,
                                        input logic rw, input logic [4:0] wa, input logic busy,
                                        input logic done, input logic err);
        return {mr, mdl, sel, rw, wa, busy, done, err};
    endfunction

    task automatic check(input string tag, input logic [13:0] expv);
        logic [13:0] obs;
        obs = {MEM_READ, MEM_DATA_LOAD, SELECT, REG_WRITE, WR_ADDR, BUSY, DONE, ERR};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at posedge+1 with the DUT idle. ready_at: wait cycle (1..T) where memory
    // answers, 0 = never. Inputs are scrambled while busy to show they are ignored.
    task automatic run_txn(input string name, input logic [2:0] cls, input logic [4:0] rd,
                           input logic lt, input int ready_at);
        logic [13:0] exp_q[$];
        logic [2:0]  sel;
        int          n;
        exp_q = {};
        case (cls)
            3'd0, 3'd2, 3'd3: begin
                sel = (cls == 3'd0) ? 3'd0 : (cls == 3'd3) ? 3'd4 : (lt ? 3'd2 : 3'd3);
                exp_q.push_back(vec(1'b0, 1'b0, sel, rd != 5'd0, rd, 1'b1, 1'b0, 1'b0));
                exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0));
            end
            3'd1: begin
                if (ready_at == 0) begin
                    for (int i = 1; i <= T; i++)
                        exp_q.push_back(vec(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0));
                    exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1));
                end else begin
                    for (int i = 1; i <= ready_at; i++)
                        exp_q.push_back(vec(1'b1, i == ready_at, 3'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0));
                    exp_q.push_back(vec(1'b0, 1'b0, 3'd1, rd != 5'd0, rd, 1'b1, 1'b0, 1'b0));
                    exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0));
                end
            end
            3'd4: exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0));
            default: exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1));
        endcase
        exp_q.push_back(14'd0);
        n = exp_q.size();

        START = 1'b1; WB_CLASS = cls; RD = rd; LT_FLAG = lt; MEM_READY = 1'($urandom);
        #1 check($sformatf("%s c0", name), 14'd0);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            START    = (c < n) ? 1'($urandom) : 1'b0;
            WB_CLASS = 3'($urandom);
            RD       = 5'($urandom);
            LT_FLAG  = 1'($urandom);
            if (cls == 3'd1 && c <= T) begin
                if (ready_at != 0 && c == ready_at) MEM_READY = 1'b1;
                else if (ready_at != 0 && c > ready_at) MEM_READY = 1'($urandom);
                else MEM_READY = 1'b0;
            end else begin
                MEM_READY = 1'($urandom);
            end
            #1 check($sformatf("%s c%0d", name, c), exp_q[c-1]);
        end
    endtask

    initial begin
        logic [2:0] rc;
        logic [4:0] rr;
        reset_n = 1'b0; START = 1'b0; WB_CLASS = 3'd0; RD = 5'd0; LT_FLAG = 1'b0; MEM_READY = 1'b1;
        #1 check("reset", 14'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        MEM_READY = 1'b1;
        #1 check("idle ignores ready", 14'd0);

        run_txn("alu rd5", 3'd0, 5'd5, 1'b0, 0);
        run_txn("load rd10 k3", 3'd1, 5'd10, 1'b0, 3);
        run_txn("load timeout", 3'd1, 5'd9, 1'b0, 0);
        run_txn("load ready last", 3'd1, 5'd9, 1'b0, T);
        run_txn("slt lt1", 3'd2, 5'd3, 1'b1, 0);
        run_txn("slt lt0", 3'd2, 5'd3, 1'b0, 0);
        run_txn("link rd0", 3'd3, 5'd0, 1'b0, 0);
        run_txn("none", 3'd4, 5'd7, 1'b0, 0);
        run_txn("bad class 110", 3'd6, 5'd1, 1'b0, 0);
        run_txn("load rd0 k1", 3'd1, 5'd0, 1'b1, 1);

        // START re-asserted mid-wait, then asynchronous reset mid-MEM_WAIT.
        START = 1'b1; WB_CLASS = 3'd1; RD = 5'd7; MEM_READY = 1'b0;
        @(posedge clk); #1;
        START = 1'b1; WB_CLASS = 3'd0;
        #1 check("rst seq w1", vec(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
        START = 1'b0;
        #1 check("rst seq w2", vec(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0));
        MEM_READY = 1'b1;
        #1 reset_n = 1'b0;
        #1 check("async reset", 14'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            MEM_READY = 1'($urandom);
            #1 check($sformatf("post reset idle %0d", i), 14'd0);
        end

        for (int i = 0; i < 40; i++) begin
            rc = 3'($urandom);
            rr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_txn($sformatf("rand%0d cls%0d", i, rc), rc, rr, 1'($urandom),
                    int'($urandom_range(0, T)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
